thresholding_axilite_loader: RTL and testbench

AXI4-Lite initiator that programs the threshold memory of a thresholding_axi instance at start-up. It takes a flat stream of threshold words on AXI-Stream and issues one AXI4-Lite write per word. Addresses are generated in the responder's {fold, pe, threshold-index, 2'b00} layout. It sits between a parameter source (DMA or ROM streamer) and the s_axilite port of the thresholding block, and reports completion and response errors.

---
 rtl/thresholding_axilite_loader.sv | 181 ++++++++++++++++++
 tb/tb_thresholding_axilite_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thresholding_axilite_loader.sv
// AXI4-Lite initiator that streams threshold words into a thresholding_axi
// responder, one single-beat write per word, addressed as {fold, pe, t, 2'b00}.
module thresholding_axilite_loader #(
  parameter int N  = 4,
  parameter int C  = 6,
  parameter int PE = 2,
  localparam int CF        = C / PE,
  localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2,
  localparam int TOTAL     = C * (2**N - 1)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [31:0]          s_axis_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | accepting the next threshold word
  // ISSUE  | AW and W channels outstanding, each retired on its own handshake
  // RESP   | waiting for the write response
  // DONE   | one-cycle completion pulse

  if ((C % PE) != 0) begin : g_bad_cfg
    $error("thresholding_axilite_loader: C must be divisible by PE");
  end

  localparam int CFB    = $clog2(CF);
  localparam int PEB    = $clog2(PE);
  localparam int CW     = (CFB > 0) ? CFB : 1;
  localparam int PW     = (PEB > 0) ? PEB : 1;
  localparam int RW     = $clog2(TOTAL + 1);
  localparam int T_LAST = 2**N - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_RESP,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [N-1:0]         t_cnt;
  logic [PW-1:0]        pe_cnt;
  logic [CW-1:0]        cf_cnt;
  logic [RW-1:0]        remaining;
  logic                 aw_ok;
  logic                 w_ok;
  logic                 last;
  logic [ADDR_BITS-1:0] cur_addr;

  // Absent fields (CF==1 or PE==1) keep their counter at zero, so the shifted
  // contribution vanishes and the address collapses to the remaining fields.
  assign cur_addr = (ADDR_BITS'(cf_cnt) << (PEB + N + 2))
                  | (ADDR_BITS'(pe_cnt) << (N + 2))
                  | (ADDR_BITS'(t_cnt)  << 2);

  assign last            = (remaining == '0);
  assign m_axilite_WSTRB = 4'hF;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n           = state;
    busy              = 1'b0;
    done              = 1'b0;
    s_axis_tready     = 1'b0;
    m_axilite_AWVALID = 1'b0;
    m_axilite_WVALID  = 1'b0;
    m_axilite_BREADY  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        busy          = 1'b1;
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        busy              = 1'b1;
        m_axilite_AWVALID = !aw_ok;
        m_axilite_WVALID  = !w_ok;
        if ((aw_ok || m_axilite_AWREADY) && (w_ok || m_axilite_WREADY))
          state_n = S_RESP;
      end
      S_RESP: begin
        busy             = 1'b1;
        m_axilite_BREADY = 1'b1;
        if (m_axilite_BVALID) state_n = last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      t_cnt            <= '0;
      pe_cnt           <= '0;
      cf_cnt           <= '0;
      remaining        <= '0;
      aw_ok            <= 1'b0;
      w_ok             <= 1'b0;
      error            <= 1'b0;
      m_axilite_AWADDR <= '0;
      m_axilite_WDATA  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            t_cnt     <= '0;
            pe_cnt    <= '0;
            cf_cnt    <= '0;
            remaining <= RW'(TOTAL - 1);
            error     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (s_axis_tvalid) begin
            m_axilite_WDATA  <= s_axis_tdata;
            m_axilite_AWADDR <= cur_addr;
            aw_ok            <= 1'b0;
            w_ok             <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (m_axilite_AWVALID && m_axilite_AWREADY) aw_ok <= 1'b1;
          if (m_axilite_WVALID && m_axilite_WREADY)   w_ok  <= 1'b1;
        end
        S_RESP: begin
          if (m_axilite_BVALID) begin
            if (m_axilite_BRESP != 2'b00) error <= 1'b1;
            if (!last) begin
              remaining <= remaining - 1'b1;
              if (t_cnt == N'(T_LAST)) begin
                t_cnt <= '0;
                if (pe_cnt == PW'(PE - 1)) begin
                  pe_cnt <= '0;
                  cf_cnt <= (cf_cnt == CW'(CF - 1)) ? '0 : cf_cnt + 1'b1;
                end else begin
                  pe_cnt <= pe_cnt + 1'b1;
                end
              end else begin
                t_cnt <= t_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// Randomized self-checking bench: behavioural AXI-Lite responder plus a
// reference address/data sequence computed from channel/threshold arithmetic.
module tb_thresholding_axilite_loader;
  localparam int T     = 15;
  localparam int TOTAL = 90;
  localparam int AB    = 9;
  localparam int SLEN  = TOTAL + 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [31:0]   s_axis_tdata = '0;
  logic          AWVALID, WVALID, BREADY;
  logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [AB-1:0] AWADDR;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP = 2'b00;

  thresholding_axilite_loader #(.N(4), .C(6), .PE(2)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .busy(busy), .done(done), .error(error),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axilite_AWVALID(AWVALID), .m_axilite_AWREADY(AWREADY), .m_axilite_AWADDR(AWADDR),
    .m_axilite_WVALID(WVALID), .m_axilite_WREADY(WREADY), .m_axilite_WDATA(WDATA),
    .m_axilite_WSTRB(WSTRB), .m_axilite_BVALID(BVALID), .m_axilite_BREADY(BREADY),
    .m_axilite_BRESP(BRESP)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad = 0;

  int aw_dly, w_dly, err_idx;
  bit b_rand, throttle, poke_start;
  int aw_cnt, w_cnt, b_wait, b_count, s_idx, cyc;
  int tready_cyc, done_cyc, done_pulses, err_at_b, stab_err;
  bit b_hs, s_hs, aw_seen, w_seen;
  logic [AB-1:0] aw_first;
  logic [31:0]   w_first;
  logic [AB-1:0] aw_q[$];
  logic [31:0]   w_q[$];
  logic [31:0]   stream_data [0:SLEN-1];

  // word k belongs to channel k/15, threshold k%15; channel = fold*2 + pe
  function automatic logic [AB-1:0] model_addr(input int k);
    int ch, t;
    ch = k / T;
    t  = k % T;
    return AB'((ch / 2) * 128 + (ch % 2) * 64 + t * 4);
  endfunction

  function automatic int seq_errors(output int first_bad);
    int n;
    n = 0;
    first_bad = -1;
    for (int k = 0; k < TOTAL; k++) begin
      if (k >= aw_q.size() || k >= w_q.size() ||
          aw_q[k] !== model_addr(k) || w_q[k] !== stream_data[k]) begin
        n++;
        if (first_bad < 0) first_bad = k;
      end
    end
    return n;
  endfunction

  task automatic resp_clear();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    aw_cnt = 0; w_cnt = 0; b_wait = 0; b_count = 0; s_idx = 0;
    b_hs = 1'b0; s_hs = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
    aw_q.delete(); w_q.delete();
    tready_cyc = -1; done_cyc = -1; done_pulses = 0; err_at_b = -1; stab_err = 0;
  endtask

  task automatic fill_stream(input bit rnd);
    for (int k = 0; k < SLEN; k++) stream_data[k] = rnd ? $urandom : 32'(k);
  endtask

  task automatic set_mode(input int awd, input int wd, input bit br, input bit thr,
                          input bit pk, input int ei);
    aw_dly = awd; w_dly = wd; b_rand = br; throttle = thr; poke_start = pk; err_idx = ei;
  endtask

  // One clock of responder, stream source and monitors, evaluated 1 time unit
  // after the rising edge; ready/valid set here take effect at the next edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    cyc++;
    if (!ap_rst_n) begin
      resp_clear();
      s_axis_tvalid = 1'b0;
      return;
    end
    if (b_hs) begin
      b_hs = 1'b0; BVALID = 1'b0; BRESP = 2'b00; b_count++;
      b_wait = b_rand ? int'($urandom_range(4, 0)) : 0;
    end
    if (s_hs) begin
      s_hs = 1'b0; s_idx++;
    end
    if (done) begin
      done_pulses++; done_cyc = cyc;
    end
    if (s_axis_tready && tready_cyc < 0) tready_cyc = cyc;
    if (error && err_at_b < 0) err_at_b = b_count;
    if (!BVALID && aw_q.size() > b_count && w_q.size() > b_count) begin
      if (b_wait <= 0) begin
        BVALID = 1'b1;
        BRESP  = (b_count == err_idx) ? 2'b10 : 2'b00;
      end else begin
        b_wait--;
      end
    end
    if (BVALID && BREADY) b_hs = 1'b1;
    AWREADY = 1'b0;
    if (AWVALID) begin
      if (!aw_seen) begin aw_seen = 1'b1; aw_first = AWADDR; end
      else if (AWADDR !== aw_first) stab_err++;
      if (aw_cnt >= aw_dly) begin
        AWREADY = 1'b1; aw_q.push_back(AWADDR); aw_cnt = 0; aw_seen = 1'b0;
      end else aw_cnt++;
    end
    WREADY = 1'b0;
    if (WVALID) begin
      if (!w_seen) begin w_seen = 1'b1; w_first = WDATA; end
      else if (WDATA !== w_first) stab_err++;
      if (w_cnt >= w_dly) begin
        WREADY = 1'b1; w_q.push_back(WDATA); w_cnt = 0; w_seen = 1'b0;
      end else w_cnt++;
    end
    s_axis_tvalid = !(throttle && (cyc % 7 == 0));
    s_axis_tdata  = (s_idx < SLEN) ? stream_data[s_idx] : 32'hDEAD_BEEF;
    if (s_axis_tvalid && s_axis_tready) s_hs = 1'b1;
  endtask

  task automatic run_load(output bit ok);
    resp_clear();
    ok = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (poke_start) start = busy && !done && ($urandom_range(3, 0) == 0);
      tick();
      if (done_pulses > 0) ok = 1'b1;
    end
    start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_axis_tready); end
    total++; if ({AWVALID, WVALID, BREADY} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b want=000", {AWVALID, WVALID, BREADY}); end
    total++; if (AWADDR !== '0) begin bad++; $display("FAIL reset_awaddr got=%h want=0", AWADDR); end
    total++; if (WDATA !== '0) begin bad++; $display("FAIL reset_wdata got=%h want=0", WDATA); end
    total++; if (WSTRB !== 4'hF) begin bad++; $display("FAIL reset_wstrb got=%h want=f", WSTRB); end
    ap_rst_n = 1'b1;
    repeat (2) tick();
    total++; if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b tready=%b want=0,0", busy, s_axis_tready); end
  endtask

  task automatic test_zero_wait();
    bit ok; int mm, fb;
    set_mode(0, 0, 0, 0, 0, -1);
    fill_stream(0);
    run_load(ok);
    mm = seq_errors(fb);
    total++; if (!ok) begin bad++; $display("FAIL zw_timeout got=no_done want=done"); end
    total++; if (mm !== 0) begin bad++; $display("FAIL zw_sequence got=%0d_bad_first=%0d want=0", mm, fb); end
    total++; if (aw_q.size() !== TOTAL || w_q.size() !== TOTAL) begin bad++; $display("FAIL zw_count got=%0d/%0d want=%0d", aw_q.size(), w_q.size(), TOTAL); end
    total++; if (aw_q[0] !== 9'h000 || w_q[0] !== 32'd0) begin bad++; $display("FAIL zw_first got=%h/%0d want=000/0", aw_q[0], w_q[0]); end
    total++; if (aw_q[50] !== 9'h0D4 || w_q[50] !== 32'd50) begin bad++; $display("FAIL zw_ch3_t5 got=%h/%0d want=0d4/50", aw_q[50], w_q[50]); end
    total++; if (aw_q[TOTAL-1] !== 9'h178 || w_q[TOTAL-1] !== 32'd89) begin bad++; $display("FAIL zw_last got=%h/%0d want=178/89", aw_q[TOTAL-1], w_q[TOTAL-1]); end
    total++; if (done_cyc - tready_cyc !== 270) begin bad++; $display("FAIL zw_cycles got=%0d want=270", done_cyc - tready_cyc); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL zw_done_pulses got=%0d want=1", done_pulses); end
    total++; if (s_idx !== TOTAL) begin bad++; $display("FAIL zw_words_taken got=%0d want=%0d", s_idx, TOTAL); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL zw_error got=%b want=0", error); end
  endtask

  task automatic test_start_on_done();
    bit seen; int mm, fb;
    set_mode(0, 0, 0, 0, 0, -1);
    fill_stream(1);
    resp_clear();
    seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL sod_timeout got=no_done want=done"); end
    total++; if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin bad++; $display("FAIL sod_ignored busy=%b tready=%b want=0,0", busy, s_axis_tready); end
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sod_still_idle got=%b want=0", busy); end
    mm = seq_errors(fb);
    total++; if (mm !== 0) begin bad++; $display("FAIL sod_sequence got=%0d_bad_first=%0d want=0", mm, fb); end
  endtask

  task automatic test_handshake_order();
    bit ok; int mm, fb;
    int awd[3] = '{0, 3, 2};
    int wd[3]  = '{3, 0, 2};
    for (int m = 0; m < 3; m++) begin
      set_mode(awd[m], wd[m], 0, 0, 0, -1);
      fill_stream(1);
      run_load(ok);
      mm = seq_errors(fb);
      total++; if (!ok) begin bad++; $display("FAIL hs%0d_timeout got=no_done want=done", m); end
      total++; if (mm !== 0) begin bad++; $display("FAIL hs%0d_sequence got=%0d_bad_first=%0d want=0", m, mm, fb); end
      total++; if (aw_q.size() !== TOTAL || w_q.size() !== TOTAL) begin bad++; $display("FAIL hs%0d_count got=%0d/%0d want=%0d", m, aw_q.size(), w_q.size(), TOTAL); end
      total++; if (stab_err !== 0) begin bad++; $display("FAIL hs%0d_stability got=%0d want=0", m, stab_err); end
    end
  endtask

  task automatic test_error_resp();
    bit ok; int mm, fb;
    set_mode(0, 0, 0, 0, 0, 17);
    fill_stream(1);
    run_load(ok);
    mm = seq_errors(fb);
    total++; if (!ok) begin bad++; $display("FAIL er_timeout got=no_done want=done"); end
    total++; if (mm !== 0) begin bad++; $display("FAIL er_sequence got=%0d_bad_first=%0d want=0", mm, fb); end
    total++; if (err_at_b !== 18) begin bad++; $display("FAIL er_set_point got=%0d want=18", err_at_b); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL er_sticky got=%b want=1", error); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL er_done_pulses got=%0d want=1", done_pulses); end
    err_idx = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL er_cleared got=%b want=0", error); end
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL er_reload_timeout got=no_done want=done"); end
    tick();
  endtask

  task automatic test_throttled();
    bit ok; int mm, fb;
    set_mode(0, 0, 1, 1, 1, -1);
    fill_stream(1);
    run_load(ok);
    mm = seq_errors(fb);
    total++; if (!ok) begin bad++; $display("FAIL th_timeout got=no_done want=done"); end
    total++; if (mm !== 0) begin bad++; $display("FAIL th_sequence got=%0d_bad_first=%0d want=0", mm, fb); end
    total++; if (done_pulses !== 1) begin bad++; $display("FAIL th_done_pulses got=%0d want=1", done_pulses); end
    total++; if (s_idx !== TOTAL) begin bad++; $display("FAIL th_words_taken got=%0d want=%0d", s_idx, TOTAL); end
    set_mode(0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_async_reset();
    bit found, ok; int mm, fb;
    set_mode(0, 0, 0, 0, 0, -1);
    fill_stream(0);
    resp_clear();
    found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (b_count == 40 && AWVALID) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL ar_reach_write40 got=not_reached want=reached"); end
    #1 ap_rst_n = 1'b0;
    #1;
    total++; if ({AWVALID, WVALID, BREADY, s_axis_tready} !== 4'b0000) begin bad++; $display("FAIL ar_valids got=%b want=0000", {AWVALID, WVALID, BREADY, s_axis_tready}); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ar_status busy=%b done=%b want=0,0", busy, done); end
    total++; if (AWADDR !== '0 || WDATA !== '0) begin bad++; $display("FAIL ar_regs got=%h/%h want=0/0", AWADDR, WDATA); end
    repeat (2) tick();
    ap_rst_n = 1'b1;
    tick();
    run_load(ok);
    mm = seq_errors(fb);
    total++; if (!ok) begin bad++; $display("FAIL ar_reload_timeout got=no_done want=done"); end
    total++; if (aw_q[0] !== 9'h000) begin bad++; $display("FAIL ar_restart_addr got=%h want=000", aw_q[0]); end
    total++; if (mm !== 0) begin bad++; $display("FAIL ar_sequence got=%0d_bad_first=%0d want=0", mm, fb); end
  endtask

  initial begin
    cyc = 0;
    set_mode(0, 0, 0, 0, 0, -1);
    fill_stream(0);
    resp_clear();
    test_reset();
    test_zero_wait();
    test_start_on_done();
    test_handshake_order();
    test_error_resp();
    test_throttled();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
